// File: rtl/spi_upload_rx_pkg.sv
// Purpose: shared constants and FSM encoding for the SPI program-upload receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a; the upload path has no stall input.
package spi_upload_rx_pkg;

    // Command bytes sent by the ARM controller.
    localparam logic [7:0]  CMD_FILE_TX_DEF   = 8'h53;
    localparam logic [7:0]  CMD_FILE_DATA_DEF = 8'h54;

    // Chip-8 programs load at 0x200.
    localparam logic [11:0] START_ADDR_DEF    = 12'h200;
    localparam int          SYNC_STAGES_DEF   = 2;

    // Last writable address; writing here ends the transfer's address range.
    localparam logic [11:0] LAST_ADDR         = 12'hFFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_PARAM = 3'd2,
        ST_DATA  = 3'd3,
        ST_SKIP  = 3'd4
    } state_t;

endpackage

// File: rtl/spi_upload_rx_if.sv
// Purpose: upload bus from the SPI receiver to the chip8 machine, plus status.
// Latency: n/a (wires only).
// Backpressure: none; the consumer must accept every upload_en strobe.
// Ports: uploading, upload_en, upload_a, upload_d, overflow, byte_count.
interface spi_upload_rx_if;
    logic        uploading;
    logic        upload_en;
    logic [11:0] upload_a;
    logic [7:0]  upload_d;
    logic        overflow;
    logic [12:0] byte_count;

    modport master (
        output uploading, upload_en, upload_a, upload_d, overflow, byte_count
    );

    modport slave (
        input uploading, upload_en, upload_a, upload_d, overflow, byte_count
    );
endinterface

// File: rtl/spi_upload_rx_bit_sync.sv
// Purpose: oversample SPI pins, detect SCK rising edges, assemble MSB-first bytes.
// Latency: byte_valid rises SYNC_STAGES+1 clk after the physical 8th SCK rise.
// Backpressure: none; byte_valid is a one-clk pulse that must be taken when seen.
// Ports: clk/res_n; spi_sck/spi_ss/spi_di raw pins; sck_rise, ss_active, byte_valid, rx_byte.
module spi_bit_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       spi_sck,
    input  logic       spi_ss,
    input  logic       spi_di,
    output logic       sck_rise,
    output logic       ss_active,
    output logic       byte_valid,
    output logic [7:0] rx_byte
);

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] ss_sync_q,  ss_sync_d;
    logic [SYNC_STAGES-1:0] di_sync_q,  di_sync_d;
    logic                   sck_prev_q, sck_prev_d;
    logic [7:0]             shift_q,    shift_d;
    logic [2:0]             bit_cnt_q,  bit_cnt_d;
    logic                   byte_valid_q, byte_valid_d;
    logic [7:0]             rx_byte_q,  rx_byte_d;

    logic sck_s, ss_s, di_s, rise;

    assign sck_s = sck_sync_q[SYNC_STAGES-1];
    assign ss_s  = ss_sync_q[SYNC_STAGES-1];
    assign di_s  = di_sync_q[SYNC_STAGES-1];
    assign rise  = sck_s & ~sck_prev_q;

    always_comb begin
        sck_sync_d   = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
        ss_sync_d    = {ss_sync_q[SYNC_STAGES-2:0],  spi_ss};
        di_sync_d    = {di_sync_q[SYNC_STAGES-2:0],  spi_di};
        sck_prev_d   = sck_s;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        byte_valid_d = 1'b0;
        rx_byte_d    = rx_byte_q;
        if (ss_s) begin
            // Deselect drops any partial byte.
            bit_cnt_d = 3'd0;
        end else if (rise) begin
            shift_d   = {shift_q[6:0], di_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                byte_valid_d = 1'b1;
                rx_byte_d    = {shift_q[6:0], di_s};
            end
        end
    end

    // Sync chains reset to the idle pin levels (SCK low, SS deasserted) so
    // reset release never fakes an edge or a select.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            sck_sync_q   <= '0;
            ss_sync_q    <= '1;
            di_sync_q    <= '0;
            sck_prev_q   <= 1'b0;
            shift_q      <= 8'h00;
            bit_cnt_q    <= 3'd0;
            byte_valid_q <= 1'b0;
            rx_byte_q    <= 8'h00;
        end else begin
            sck_sync_q   <= sck_sync_d;
            ss_sync_q    <= ss_sync_d;
            di_sync_q    <= di_sync_d;
            sck_prev_q   <= sck_prev_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_valid_q <= byte_valid_d;
            rx_byte_q    <= rx_byte_d;
        end
    end

    assign sck_rise   = rise & ~ss_s;
    assign ss_active  = ~ss_s;
    assign byte_valid = byte_valid_q;
    assign rx_byte    = rx_byte_q;

endmodule

// File: rtl/spi_upload_rx.sv
// Purpose: SPI slave decoding MiST file-transfer commands into chip8 byte writes.
// Latency: upload_en fires SYNC_STAGES+2 clk after the 8th SCK rise of a data byte.
// Backpressure: none; SCK <= clk/4 guarantees strobes are never back to back.
// Ports: clk/res_n; spi_sck/spi_ss/spi_di pins; up (master) carries the upload bus and status.
module spi_upload_rx
    import spi_upload_rx_pkg::*;
#(
    parameter logic [11:0] START_ADDR    = START_ADDR_DEF,
    parameter int          SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter logic [7:0]  CMD_FILE_TX   = CMD_FILE_TX_DEF,
    parameter logic [7:0]  CMD_FILE_DATA = CMD_FILE_DATA_DEF
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             spi_sck,
    input  logic             spi_ss,
    input  logic             spi_di,
    spi_upload_rx_if.master  up
);

    logic       sck_rise, ss_active, byte_valid;
    logic [7:0] rx_byte;

    spi_bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bit_sync (
        .clk        (clk),
        .res_n      (res_n),
        .spi_sck    (spi_sck),
        .spi_ss     (spi_ss),
        .spi_di     (spi_di),
        .sck_rise   (sck_rise),
        .ss_active  (ss_active),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte)
    );

    state_t      state_q, state_d;
    logic        uploading_q,  uploading_d;
    logic        upload_en_q,  upload_en_d;
    logic [11:0] upload_a_q,   upload_a_d;
    logic [7:0]  upload_d_q,   upload_d_d;
    logic        overflow_q,   overflow_d;
    logic [12:0] byte_count_q, byte_count_d;

    logic byte_in;
    assign byte_in = byte_valid & ss_active;

    // State register.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (!ss_active) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:  if (sck_rise) state_d = ST_CMD;
                ST_CMD: begin
                    if (byte_in) begin
                        if (rx_byte == CMD_FILE_TX)        state_d = ST_PARAM;
                        else if (rx_byte == CMD_FILE_DATA) state_d = ST_DATA;
                        else                               state_d = ST_SKIP;
                    end
                end
                ST_PARAM: if (byte_in) state_d = ST_SKIP;
                ST_DATA:  state_d = ST_DATA;
                ST_SKIP:  state_d = ST_SKIP;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Output / datapath logic.
    always_comb begin
        uploading_d  = uploading_q;
        upload_en_d  = 1'b0;
        upload_a_d   = upload_a_q;
        upload_d_d   = upload_d_q;
        overflow_d   = overflow_q;
        byte_count_d = byte_count_q;

        // Address and count advance the cycle after a strobe, so upload_a
        // stays stable while upload_en is high. The top address is never
        // passed; instead further writes are blocked by overflow.
        if (upload_en_q) begin
            byte_count_d = byte_count_q + 13'd1;
            if (upload_a_q == LAST_ADDR) overflow_d = 1'b1;
            else                         upload_a_d = upload_a_q + 12'd1;
        end

        if (byte_in) begin
            if (state_q == ST_PARAM) begin
                if (rx_byte != 8'h00) begin
                    uploading_d  = 1'b1;
                    upload_a_d   = START_ADDR;
                    byte_count_d = 13'd0;
                    overflow_d   = 1'b0;
                end else begin
                    uploading_d  = 1'b0;
                end
            end else if (state_q == ST_DATA && uploading_q && !overflow_q) begin
                upload_en_d = 1'b1;
                upload_d_d  = rx_byte;
            end
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            uploading_q  <= 1'b0;
            upload_en_q  <= 1'b0;
            upload_a_q   <= START_ADDR;
            upload_d_q   <= 8'h00;
            overflow_q   <= 1'b0;
            byte_count_q <= 13'd0;
        end else begin
            uploading_q  <= uploading_d;
            upload_en_q  <= upload_en_d;
            upload_a_q   <= upload_a_d;
            upload_d_q   <= upload_d_d;
            overflow_q   <= overflow_d;
            byte_count_q <= byte_count_d;
        end
    end

    assign up.uploading  = uploading_q;
    assign up.upload_en  = upload_en_q;
    assign up.upload_a   = upload_a_q;
    assign up.upload_d   = upload_d_q;
    assign up.overflow   = overflow_q;
    assign up.byte_count = byte_count_q;

endmodule
